parc_core_scoreboard: RTL and testbench

Issue-stage scoreboard for the out-of-order-completion PARC core. It sits directly upstream of the reorder buffer (ROB). Each cycle it decides whether the instruction in Dhl may issue, checking RAW, WAW, writeback-port and ROB-full hazards. For every issued instruction that writes a register it allocates a ROB slot, then tracks the instruction through its functional-unit latency and drives the ROB fill port when the result reaches writeback. ROB commits clear register pending state.

---
 rtl/parc_core_scoreboard_pkg.sv | 32 +++
 rtl/parc_core_fill_tag_pipe.sv | 59 +++++
 rtl/parc_core_scoreboard.sv | 139 +++++++++++++
 tb/tb_parc_core_scoreboard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/parc_core_scoreboard_pkg.sv
// rtl/parc_core_scoreboard_pkg.sv - shared constants and latency codes for the PARC issue scoreboard
package parc_core_scoreboard_pkg;

   localparam int NUM_REGS   = 32;
   localparam int ROB_SLOT_W = 4;
   localparam int MAX_LAT    = 4;

   // Latency class codes as presented on lat_Dhl
   typedef enum logic [1:0] {
      LAT_ALU  = 2'd0,
      LAT_MEM  = 2'd1,
      LAT_MUL  = 2'd2,
      LAT_LONG = 2'd3
   } lat_e;

   // Issue-to-fill cycle counts for each class
   localparam logic [2:0] LAT_ALU_CYC = 3'd1;
   localparam logic [2:0] LAT_MEM_CYC = 3'd2;
   localparam logic [2:0] LAT_MUL_CYC = 3'd4;

   // Code 3 has no unit of its own and is scheduled like the slowest unit
   function automatic logic [2:0] lat_cycles(input logic [1:0] code);
      logic [2:0] cyc;
      case (code)
         LAT_ALU: cyc = LAT_ALU_CYC;
         LAT_MEM: cyc = LAT_MEM_CYC;
         default: cyc = LAT_MUL_CYC;
      endcase
      return cyc;
   endfunction

endpackage

// File: rtl/parc_core_fill_tag_pipe.sv
// rtl/parc_core_fill_tag_pipe.sv - {val, slot} delay line with a variable insert stage feeding the ROB fill port
module parc_core_fill_tag_pipe #(
   parameter int MAX_LAT = 4,
   parameter int SLOT_W  = 4,
   parameter int STAGE_W = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ins_val_i,
   input  logic [STAGE_W-1:0] ins_stage_i,
   input  logic [SLOT_W-1:0] ins_slot_i,
   output logic              fill_val_o,
   output logic [SLOT_W-1:0] fill_slot_o
);

   logic [MAX_LAT-1:0] val_q, val_d, val_v;
   logic [SLOT_W-1:0]  slot_q [MAX_LAT];
   logic [SLOT_W-1:0]  slot_d [MAX_LAT];
   logic [SLOT_W-1:0]  slot_v [MAX_LAT];
   logic               fill_val_q, fill_val_d;
   logic [SLOT_W-1:0]  fill_slot_q, fill_slot_d;

   // Insert the new tag at its stage, then advance everything one stage toward the fill port
   always_comb begin
      val_v = val_q;
      for (int k = 0; k < MAX_LAT; k++) slot_v[k] = slot_q[k];
      if (ins_val_i) begin
         val_v[ins_stage_i]  = 1'b1;
         slot_v[ins_stage_i] = ins_slot_i;
      end
      val_d = '0;
      for (int k = 0; k < MAX_LAT; k++) slot_d[k] = '0;
      for (int k = 0; k < MAX_LAT - 1; k++) begin
         val_d[k]  = val_v[k+1];
         slot_d[k] = slot_v[k+1];
      end
      fill_val_d  = val_v[0];
      fill_slot_d = val_v[0] ? slot_v[0] : '0;
   end

   // Tag stages and the registered fill port; reset drops every tag in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         val_q       <= '0;
         fill_val_q  <= 1'b0;
         fill_slot_q <= '0;
         for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= '0;
      end else begin
         val_q       <= val_d;
         fill_val_q  <= fill_val_d;
         fill_slot_q <= fill_slot_d;
         for (int k = 0; k < MAX_LAT; k++) slot_q[k] <= slot_d[k];
      end
   end

   assign fill_val_o  = fill_val_q;
   assign fill_slot_o = fill_slot_q;

endmodule

// File: rtl/parc_core_scoreboard.sv
// rtl/parc_core_scoreboard.sv - issue-stage hazard scoreboard and ROB allocate/fill sequencer
module parc_core_scoreboard #(
   parameter int NUM_REGS   = parc_core_scoreboard_pkg::NUM_REGS,
   parameter int ROB_SLOT_W = parc_core_scoreboard_pkg::ROB_SLOT_W,
   parameter int MAX_LAT    = parc_core_scoreboard_pkg::MAX_LAT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  inst_val_Dhl,
   input  logic                  src0_en_Dhl,
   input  logic [4:0]            src0_addr_Dhl,
   input  logic                  src1_en_Dhl,
   input  logic [4:0]            src1_addr_Dhl,
   input  logic                  dst_en_Dhl,
   input  logic [4:0]            dst_addr_Dhl,
   input  logic [1:0]            lat_Dhl,
   output logic                  stall_Dhl,
   output logic                  op0_byp_Xhl,
   output logic                  op1_byp_Xhl,
   output logic                  rob_alloc_req_val,
   input  logic                  rob_alloc_req_rdy,
   output logic [4:0]            rob_alloc_req_preg,
   input  logic [ROB_SLOT_W-1:0] rob_alloc_resp_slot,
   output logic                  rob_fill_val,
   output logic [ROB_SLOT_W-1:0] rob_fill_slot,
   input  logic                  rob_commit_wen,
   input  logic [ROB_SLOT_W-1:0] rob_commit_slot,
   input  logic [4:0]            rob_commit_rf_waddr
);

   import parc_core_scoreboard_pkg::*;

   localparam int STAGE_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   logic [NUM_REGS-1:0]   pend_q, pend_d;
   logic [ROB_SLOT_W-1:0] slot_q [NUM_REGS];
   logic [ROB_SLOT_W-1:0] slot_d [NUM_REGS];
   logic [2:0]            cnt_q  [NUM_REGS];
   logic [2:0]            cnt_d  [NUM_REGS];
   logic [MAX_LAT-1:0]    wb_resv_q, wb_resv_d, wb_resv_set;
   logic                  op0_byp_q, op0_byp_d, op1_byp_q, op1_byp_d;

   logic [2:0]            lat_cyc, lat_idx;
   logic [STAGE_W-1:0]    lat_stage;
   logic                  src0_live, src1_live, dst_live;
   logic                  raw0, raw1, byp0, byp1, waw, port_hz, rob_hz;
   logic                  issue, alloc;

   assign lat_cyc   = lat_cycles(lat_Dhl);
   assign lat_idx   = lat_cyc - 3'd1;
   assign lat_stage = lat_idx[STAGE_W-1:0];

   // Hazard evaluation on current state only; commits clearing pend are not forwarded
   always_comb begin
      src0_live = src0_en_Dhl && (src0_addr_Dhl != 5'd0) && pend_q[src0_addr_Dhl];
      src1_live = src1_en_Dhl && (src1_addr_Dhl != 5'd0) && pend_q[src1_addr_Dhl];
      dst_live  = dst_en_Dhl && (dst_addr_Dhl != 5'd0);
      raw0      = src0_live && (cnt_q[src0_addr_Dhl] != 3'd1);
      raw1      = src1_live && (cnt_q[src1_addr_Dhl] != 3'd1);
      byp0      = src0_live && (cnt_q[src0_addr_Dhl] == 3'd1);
      byp1      = src1_live && (cnt_q[src1_addr_Dhl] == 3'd1);
      waw       = dst_live && pend_q[dst_addr_Dhl];
      port_hz   = wb_resv_q[lat_stage];
      rob_hz    = dst_live && !rob_alloc_req_rdy;
      stall_Dhl = inst_val_Dhl && (raw0 || raw1 || waw || port_hz || rob_hz);
      issue     = inst_val_Dhl && !stall_Dhl;
      alloc     = issue && dst_live;
   end

   assign rob_alloc_req_val  = alloc;
   assign rob_alloc_req_preg = dst_addr_Dhl;

   // Next register state: countdown, commit clear, then allocation; cnt loads already one cycle along
   always_comb begin
      pend_d = pend_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         slot_d[r] = slot_q[r];
         cnt_d[r]  = (cnt_q[r] != 3'd0) ? cnt_q[r] - 3'd1 : 3'd0;
      end
      if (rob_commit_wen && (rob_commit_rf_waddr != 5'd0) &&
          (slot_q[rob_commit_rf_waddr] == rob_commit_slot)) begin
         pend_d[rob_commit_rf_waddr] = 1'b0;
      end
      if (alloc) begin
         pend_d[dst_addr_Dhl] = 1'b1;
         slot_d[dst_addr_Dhl] = rob_alloc_resp_slot;
         cnt_d[dst_addr_Dhl]  = lat_idx;
      end
      pend_d[0] = 1'b0;

      wb_resv_set = wb_resv_q;
      if (issue) wb_resv_set[lat_stage] = 1'b1;
      wb_resv_d = wb_resv_set >> 1;

      op0_byp_d = issue && byp0;
      op1_byp_d = issue && byp1;
   end

   // Scoreboard state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q    <= '0;
         wb_resv_q <= '0;
         op0_byp_q <= 1'b0;
         op1_byp_q <= 1'b0;
         for (int r = 0; r < NUM_REGS; r++) begin
            slot_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
      end else begin
         pend_q    <= pend_d;
         wb_resv_q <= wb_resv_d;
         op0_byp_q <= op0_byp_d;
         op1_byp_q <= op1_byp_d;
         for (int r = 0; r < NUM_REGS; r++) begin
            slot_q[r] <= slot_d[r];
            cnt_q[r]  <= cnt_d[r];
         end
      end
   end

   assign op0_byp_Xhl = op0_byp_q;
   assign op1_byp_Xhl = op1_byp_q;

   parc_core_fill_tag_pipe #(
      .MAX_LAT (MAX_LAT),
      .SLOT_W  (ROB_SLOT_W),
      .STAGE_W (STAGE_W)
   ) u_fill_tag_pipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .ins_val_i   (alloc),
      .ins_stage_i (lat_stage),
      .ins_slot_i  (rob_alloc_resp_slot),
      .fill_val_o  (rob_fill_val),
      .fill_slot_o (rob_fill_slot)
   );

endmodule

// File: tb/tb_parc_core_scoreboard.sv
// tb/tb_parc_core_scoreboard.sv - directed self-checking bench for parc_core_scoreboard
module tb_parc_core_scoreboard;
   import parc_core_scoreboard_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       inst_val_Dhl, src0_en_Dhl, src1_en_Dhl, dst_en_Dhl;
   logic [4:0] src0_addr_Dhl, src1_addr_Dhl, dst_addr_Dhl;
   logic [1:0] lat_Dhl;
   logic       stall_Dhl, op0_byp_Xhl, op1_byp_Xhl;
   logic       rob_alloc_req_val, rob_alloc_req_rdy;
   logic [4:0] rob_alloc_req_preg;
   logic [3:0] rob_alloc_resp_slot;
   logic       rob_fill_val;
   logic [3:0] rob_fill_slot;
   logic       rob_commit_wen;
   logic [3:0] rob_commit_slot;
   logic [4:0] rob_commit_rf_waddr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   parc_core_scoreboard dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .inst_val_Dhl        (inst_val_Dhl),
      .src0_en_Dhl         (src0_en_Dhl),
      .src0_addr_Dhl       (src0_addr_Dhl),
      .src1_en_Dhl         (src1_en_Dhl),
      .src1_addr_Dhl       (src1_addr_Dhl),
      .dst_en_Dhl          (dst_en_Dhl),
      .dst_addr_Dhl        (dst_addr_Dhl),
      .lat_Dhl             (lat_Dhl),
      .stall_Dhl           (stall_Dhl),
      .op0_byp_Xhl         (op0_byp_Xhl),
      .op1_byp_Xhl         (op1_byp_Xhl),
      .rob_alloc_req_val   (rob_alloc_req_val),
      .rob_alloc_req_rdy   (rob_alloc_req_rdy),
      .rob_alloc_req_preg  (rob_alloc_req_preg),
      .rob_alloc_resp_slot (rob_alloc_resp_slot),
      .rob_fill_val        (rob_fill_val),
      .rob_fill_slot       (rob_fill_slot),
      .rob_commit_wen      (rob_commit_wen),
      .rob_commit_slot     (rob_commit_slot),
      .rob_commit_rf_waddr (rob_commit_rf_waddr)
   );

   task automatic set_idle();
      inst_val_Dhl = 1'b0; src0_en_Dhl = 1'b0; src1_en_Dhl = 1'b0; dst_en_Dhl = 1'b0;
      src0_addr_Dhl = 5'd0; src1_addr_Dhl = 5'd0; dst_addr_Dhl = 5'd0; lat_Dhl = 2'd0;
      rob_alloc_resp_slot = 4'd0;
      rob_commit_wen = 1'b0; rob_commit_slot = 4'd0; rob_commit_rf_waddr = 5'd0;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      set_idle();
   endtask

   task automatic drive_op(input logic s0en, input logic [4:0] s0, input logic s1en, input logic [4:0] s1,
                           input logic den, input logic [4:0] d, input logic [1:0] lat, input logic [3:0] slot);
      inst_val_Dhl = 1'b1;
      src0_en_Dhl = s0en; src0_addr_Dhl = s0;
      src1_en_Dhl = s1en; src1_addr_Dhl = s1;
      dst_en_Dhl = den; dst_addr_Dhl = d;
      lat_Dhl = lat; rob_alloc_resp_slot = slot;
   endtask

   task automatic drive_commit(input logic [3:0] slot, input logic [4:0] waddr);
      rob_commit_wen = 1'b1; rob_commit_slot = slot; rob_commit_rf_waddr = waddr;
   endtask

   task automatic test_reset();
      bit seen_fill;
      set_idle();
      rob_alloc_req_rdy = 1'b1;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall_Dhl); end
      checks++; if (rob_alloc_req_val !== 1'b0) begin failures++; $display("FAIL reset_alloc_val got=%b want=0", rob_alloc_req_val); end
      checks++; if ({rob_fill_val, rob_fill_slot} !== 5'd0) begin failures++; $display("FAIL reset_fill got=%b/%0d want=0/0", rob_fill_val, rob_fill_slot); end
      checks++; if ({op0_byp_Xhl, op1_byp_Xhl} !== 2'b00) begin failures++; $display("FAIL reset_byp got=%b%b want=00", op0_byp_Xhl, op1_byp_Xhl); end
      @(negedge clk);
      reset_n = 1'b1;
      seen_fill = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rob_fill_val !== 1'b0) seen_fill = 1'b1;
      end
      checks++; if (seen_fill !== 1'b0) begin failures++; $display("FAIL idle_no_fill got=%b want=0", seen_fill); end
   endtask

   task automatic test_alu_commit();
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd3, LAT_ALU, 4'd5); #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL alu_issue_stall got=%b want=0", stall_Dhl); end
      checks++; if (rob_alloc_req_val !== 1'b1 || rob_alloc_req_preg !== 5'd3) begin failures++; $display("FAIL alu_alloc got=%b/%0d want=1/3", rob_alloc_req_val, rob_alloc_req_preg); end
      next_cycle(); drive_op(1, 5'd3, 0, 0, 0, 0, LAT_ALU, 4'd0); #1;
      checks++; if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd5) begin failures++; $display("FAIL alu_fill got=%b/%0d want=1/5", rob_fill_val, rob_fill_slot); end
      checks++; if (stall_Dhl !== 1'b1) begin failures++; $display("FAIL alu_reader_filled_stall got=%b want=1", stall_Dhl); end
      next_cycle(); drive_op(1, 5'd3, 0, 0, 0, 0, LAT_ALU, 4'd0); drive_commit(4'd6, 5'd3); #1;
      checks++; if (rob_fill_val !== 1'b0) begin failures++; $display("FAIL alu_fill_once got=%b want=0", rob_fill_val); end
      checks++; if (stall_Dhl !== 1'b1) begin failures++; $display("FAIL alu_reader_mismatch_stall got=%b want=1", stall_Dhl); end
      next_cycle(); drive_op(1, 5'd3, 0, 0, 0, 0, LAT_ALU, 4'd0); drive_commit(4'd5, 5'd3); #1;
      checks++; if (stall_Dhl !== 1'b1) begin failures++; $display("FAIL alu_reader_commit_cycle_stall got=%b want=1", stall_Dhl); end
      next_cycle(); drive_op(1, 5'd3, 0, 0, 0, 0, LAT_ALU, 4'd0); #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL alu_reader_after_commit got=%b want=0", stall_Dhl); end
      next_cycle(); #1;
      checks++; if (op0_byp_Xhl !== 1'b0) begin failures++; $display("FAIL alu_reader_byp got=%b want=0", op0_byp_Xhl); end
   endtask

   task automatic test_mul_dep();
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd4, LAT_MUL, 4'd9); #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL mul_issue_stall got=%b want=0", stall_Dhl); end
      for (int c = 1; c <= 3; c++) begin
         next_cycle(); drive_op(0, 0, 1, 5'd4, 0, 0, LAT_MEM, 4'd0); #1;
         checks++;
         if (stall_Dhl !== (c < 3)) begin failures++; $display("FAIL mul_dep_stall_c%0d got=%b want=%b", c, stall_Dhl, (c < 3)); end
      end
      next_cycle(); #1;
      checks++; if ({op0_byp_Xhl, op1_byp_Xhl} !== 2'b01) begin failures++; $display("FAIL mul_dep_byp got=%b%b want=01", op0_byp_Xhl, op1_byp_Xhl); end
      checks++; if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd9) begin failures++; $display("FAIL mul_fill got=%b/%0d want=1/9", rob_fill_val, rob_fill_slot); end
      next_cycle(); drive_commit(4'd9, 5'd4); #1;
      checks++; if ({op1_byp_Xhl, rob_fill_val} !== 2'b00) begin failures++; $display("FAIL mul_dep_after got=%b%b want=00", op1_byp_Xhl, rob_fill_val); end
   endtask

   task automatic test_port();
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd10, LAT_MUL, 4'd1); #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL port_mul_stall got=%b want=0", stall_Dhl); end
      next_cycle();
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd11, LAT_MEM, 4'd2); #1;
      checks++; if (stall_Dhl !== 1'b1 || rob_alloc_req_val !== 1'b0) begin failures++; $display("FAIL port_mem_c2 got=%b/%b want=1/0", stall_Dhl, rob_alloc_req_val); end
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd11, LAT_MEM, 4'd2); #1;
      checks++; if (stall_Dhl !== 1'b0 || rob_alloc_req_val !== 1'b1) begin failures++; $display("FAIL port_mem_c3 got=%b/%b want=0/1", stall_Dhl, rob_alloc_req_val); end
      next_cycle(); drive_op(0, 0, 0, 0, 0, 0, LAT_ALU, 4'd0); #1;
      checks++; if (stall_Dhl !== 1'b1) begin failures++; $display("FAIL port_alu_c4 got=%b want=1", stall_Dhl); end
      checks++; if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd1) begin failures++; $display("FAIL port_fill_c4 got=%b/%0d want=1/1", rob_fill_val, rob_fill_slot); end
      next_cycle(); drive_commit(4'd1, 5'd10); #1;
      checks++; if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd2) begin failures++; $display("FAIL port_fill_c5 got=%b/%0d want=1/2", rob_fill_val, rob_fill_slot); end
      next_cycle(); drive_commit(4'd2, 5'd11); #1;
      checks++; if (rob_fill_val !== 1'b0) begin failures++; $display("FAIL port_fill_c6 got=%b want=0", rob_fill_val); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] want_slot;
      for (int i = 0; i < 5; i++) begin
         next_cycle();
         if (i < 4) drive_op(0, 0, 0, 0, 1, 5'(21 + i), LAT_ALU, 4'(14 + i));
         #1;
         if (i < 4) begin
            checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL b2b_stall_%0d got=%b want=0", i, stall_Dhl); end
         end
         if (i > 0) begin
            want_slot = 4'(13 + i);
            checks++;
            if (rob_fill_val !== 1'b1 || rob_fill_slot !== want_slot) begin failures++; $display("FAIL b2b_fill_%0d got=%b/%0d want=1/%0d", i, rob_fill_val, rob_fill_slot, want_slot); end
         end
      end
      next_cycle(); #1;
      checks++; if (rob_fill_val !== 1'b0) begin failures++; $display("FAIL b2b_fill_end got=%b want=0", rob_fill_val); end
   endtask

   task automatic test_rob_waw();
      next_cycle(); rob_alloc_req_rdy = 1'b0; drive_op(0, 0, 0, 0, 1, 5'd7, LAT_ALU, 4'd0); #1;
      checks++; if (stall_Dhl !== 1'b1 || rob_alloc_req_val !== 1'b0) begin failures++; $display("FAIL rob_full got=%b/%b want=1/0", stall_Dhl, rob_alloc_req_val); end
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd0, LAT_ALU, 4'd0); #1;
      checks++; if (stall_Dhl !== 1'b0 || rob_alloc_req_val !== 1'b0) begin failures++; $display("FAIL rob_full_r0 got=%b/%b want=0/0", stall_Dhl, rob_alloc_req_val); end
      next_cycle(); rob_alloc_req_rdy = 1'b1; drive_op(0, 0, 0, 0, 1, 5'd7, LAT_MUL, 4'd12); #1;
      checks++; if (stall_Dhl !== 1'b0 || rob_alloc_req_val !== 1'b1) begin failures++; $display("FAIL waw_first got=%b/%b want=0/1", stall_Dhl, rob_alloc_req_val); end
      for (int i = 0; i < 5; i++) begin
         next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd7, LAT_ALU, 4'd13);
         if (i == 4) drive_commit(4'd12, 5'd7);
         #1;
         checks++; if (stall_Dhl !== 1'b1) begin failures++; $display("FAIL waw_stall_%0d got=%b want=1", i, stall_Dhl); end
         if (i == 3) begin
            checks++; if (rob_fill_val !== 1'b1 || rob_fill_slot !== 4'd12) begin failures++; $display("FAIL waw_mul_fill got=%b/%0d want=1/12", rob_fill_val, rob_fill_slot); end
         end
      end
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd7, LAT_ALU, 4'd13); #1;
      checks++; if (stall_Dhl !== 1'b0 || rob_alloc_req_val !== 1'b1) begin failures++; $display("FAIL waw_after_commit got=%b/%b want=0/1", stall_Dhl, rob_alloc_req_val); end
   endtask

   task automatic test_reset_midflight();
      bit seen_fill;
      next_cycle(); drive_op(0, 0, 0, 0, 1, 5'd20, LAT_MUL, 4'd3); #1;
      checks++; if (stall_Dhl !== 1'b0) begin failures++; $display("FAIL mid_mul_stall got=%b want=0", stall_Dhl); end
      next_cycle(); reset_n = 1'b0; #1;
      checks++; if ({rob_fill_val, op0_byp_Xhl, op1_byp_Xhl} !== 3'b000) begin failures++; $display("FAIL mid_reset_outs got=%b%b%b want=000", rob_fill_val, op0_byp_Xhl, op1_byp_Xhl); end
      next_cycle(); reset_n = 1'b1;
      seen_fill = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rob_fill_val !== 1'b0) seen_fill = 1'b1;
      end
      checks++; if (seen_fill !== 1'b0) begin failures++; $display("FAIL mid_no_fill got=%b want=0", seen_fill); end
      next_cycle(); drive_op(1, 5'd20, 1, 5'd7, 1, 5'd20, LAT_MUL, 4'd4); #1;
      checks++; if (stall_Dhl !== 1'b0 || rob_alloc_req_val !== 1'b1) begin failures++; $display("FAIL mid_state_clear got=%b/%b want=0/1", stall_Dhl, rob_alloc_req_val); end
      next_cycle(); #1;
      checks++; if ({op0_byp_Xhl, op1_byp_Xhl} !== 2'b00) begin failures++; $display("FAIL mid_byp got=%b%b want=00", op0_byp_Xhl, op1_byp_Xhl); end
   endtask

   initial begin
      test_reset();
      test_alu_commit();
      test_mul_dep();
      test_port();
      test_back_to_back();
      test_rob_waw();
      test_reset_midflight();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
